switch_event_decoder: RTL and testbench

Consumer end of the debounced switch interface. Takes the clean per-switch levels produced by the debounce stage and turns them into single-cycle events per switch:
- press
- release
- long-press
- auto-repeat while held

Sits between the switch debounce block and application logic such as the 7-segment counter/menu control, so downstream logic never does its own edge detection or hold timing.

---
 rtl/switch_event_decoder.sv | 114 +++++++++++
 tb/tb_switch_event_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/switch_event_decoder.sv
// Turns debounced per-switch levels into single-cycle press, release, long-press and
// auto-repeat pulses, plus a held level. Every channel is independent and all outputs are registered.
module switch_event_decoder #(
    parameter int NUM_SW            = 4,
    parameter int LONG_PRESS_CYCLES = 12500000,
    parameter int REPEAT_CYCLES     = 2500000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_SW-1:0] i_Switches,
    input  logic              i_Repeat_En,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_Long,
    output logic [NUM_SW-1:0] o_Repeat,
    output logic [NUM_SW-1:0] o_Held
);

    localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_LONG
    } state_t;

    state_t            stateQ [NUM_SW];
    logic  [CNT_W-1:0] countQ [NUM_SW];
    logic [NUM_SW-1:0] prevQ;
    logic [NUM_SW-1:0] pressQ;
    logic [NUM_SW-1:0] releaseQ;
    logic [NUM_SW-1:0] longQ;
    logic [NUM_SW-1:0] repeatQ;
    logic [NUM_SW-1:0] heldQ;

    assign o_Press   = pressQ;
    assign o_Release = releaseQ;
    assign o_Long    = longQ;
    assign o_Repeat  = repeatQ;
    assign o_Held    = heldQ;

    // Release is checked before any threshold so a fall on the threshold edge suppresses long/repeat.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prevQ    <= '0;
            pressQ   <= '0;
            releaseQ <= '0;
            longQ    <= '0;
            repeatQ  <= '0;
            heldQ    <= '0;
            for (int n = 0; n < NUM_SW; n++) begin
                stateQ[n] <= ST_IDLE;
                countQ[n] <= '0;
            end
        end else begin
            prevQ <= i_Switches;
            for (int n = 0; n < NUM_SW; n++) begin
                pressQ[n]   <= 1'b0;
                releaseQ[n] <= 1'b0;
                longQ[n]    <= 1'b0;
                repeatQ[n]  <= 1'b0;
                case (stateQ[n])
                    ST_IDLE: begin
                        if (i_Switches[n] && !prevQ[n]) begin
                            pressQ[n] <= 1'b1;
                            heldQ[n]  <= 1'b1;
                            stateQ[n] <= ST_HOLD;
                            countQ[n] <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!i_Switches[n]) begin
                            releaseQ[n] <= 1'b1;
                            heldQ[n]    <= 1'b0;
                            stateQ[n]   <= ST_IDLE;
                            countQ[n]   <= '0;
                        end else if (countQ[n] == LONG_LAST) begin
                            longQ[n]  <= 1'b1;
                            stateQ[n] <= ST_LONG;
                            countQ[n] <= '0;
                        end else begin
                            countQ[n] <= countQ[n] + CNT_ONE;
                        end
                    end
                    ST_LONG: begin
                        if (!i_Switches[n]) begin
                            releaseQ[n] <= 1'b1;
                            heldQ[n]    <= 1'b0;
                            stateQ[n]   <= ST_IDLE;
                            countQ[n]   <= '0;
                        end else if (!i_Repeat_En) begin
                            countQ[n] <= '0;
                        end else if (countQ[n] == REPEAT_LAST) begin
                            repeatQ[n] <= 1'b1;
                            countQ[n]  <= '0;
                        end else begin
                            countQ[n] <= countQ[n] + CNT_ONE;
                        end
                    end
                    default: begin
                        heldQ[n]  <= 1'b0;
                        stateQ[n] <= ST_IDLE;
                        countQ[n] <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_event_decoder.sv
// Directed and random stimulus for switch_event_decoder, compared every cycle against a
// timestamp-based reference model of the press/hold/repeat rules.
module tb_switch_event_decoder;

    localparam int NSW = 4;
    localparam int LONG_CYC = 8;
    localparam int REP_CYC = 3;

    logic           i_Clk = 1'b0;
    logic           i_Rst_L = 1'b0;
    logic [NSW-1:0] i_Switches = '0;
    logic           i_Repeat_En = 1'b0;
    logic [NSW-1:0] o_Press, o_Release, o_Long, o_Repeat, o_Held;

    switch_event_decoder #(
        .NUM_SW(NSW),
        .LONG_PRESS_CYCLES(LONG_CYC),
        .REPEAT_CYCLES(REP_CYC)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Switches(i_Switches),
        .i_Repeat_En(i_Repeat_En),
        .o_Press(o_Press),
        .o_Release(o_Release),
        .o_Long(o_Long),
        .o_Repeat(o_Repeat),
        .o_Held(o_Held)
    );

    always #5 i_Clk = ~i_Clk;

    int checkCount = 0;
    int passCount = 0;

    // Model keeps edge timestamps instead of counters: when the hold began and when the repeat interval last restarted.
    int   edgeNum = 0;
    logic mActive [NSW];
    logic mLong [NSW];
    logic mPrev [NSW];
    int   mRise [NSW];
    int   mRef [NSW];
    logic [NSW-1:0] expPress, expRelease, expLong, expRepeat, expHeld;
    int   obsRepeat [NSW];
    int   obsLong [NSW];
    int   obsPressCount [NSW];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edgeNum, observed, expected);
    endtask

    task automatic modelStep(input logic [NSW-1:0] sw, input logic en, input logic rstL);
        edgeNum++;
        expPress = '0;
        expRelease = '0;
        expLong = '0;
        expRepeat = '0;
        for (int n = 0; n < NSW; n++) begin
            if (!rstL) begin
                mActive[n] = 1'b0;
                mLong[n] = 1'b0;
                mPrev[n] = 1'b0;
            end else begin
                if (!mActive[n]) begin
                    if (sw[n] && !mPrev[n]) begin
                        expPress[n] = 1'b1;
                        mActive[n] = 1'b1;
                        mLong[n] = 1'b0;
                        mRise[n] = edgeNum;
                    end
                end else if (!sw[n]) begin
                    expRelease[n] = 1'b1;
                    mActive[n] = 1'b0;
                    mLong[n] = 1'b0;
                end else if (!mLong[n]) begin
                    if (edgeNum - mRise[n] == LONG_CYC) begin
                        expLong[n] = 1'b1;
                        mLong[n] = 1'b1;
                        mRef[n] = edgeNum;
                    end
                end else if (!en) begin
                    mRef[n] = edgeNum;
                end else if (edgeNum - mRef[n] == REP_CYC) begin
                    expRepeat[n] = 1'b1;
                    mRef[n] = edgeNum;
                end
                mPrev[n] = sw[n];
            end
            expHeld[n] = mActive[n];
        end
    endtask

    task automatic applyStimulus(input logic [NSW-1:0] sw, input logic en, input logic rstL);
        i_Switches = sw;
        i_Repeat_En = en;
        i_Rst_L = rstL;
        @(posedge i_Clk);
        modelStep(sw, en, rstL);
        #1;
        checkOutput("press", 32'(o_Press), 32'(expPress));
        checkOutput("release", 32'(o_Release), 32'(expRelease));
        checkOutput("long", 32'(o_Long), 32'(expLong));
        checkOutput("repeat", 32'(o_Repeat), 32'(expRepeat));
        checkOutput("held", 32'(o_Held), 32'(expHeld));
        for (int n = 0; n < NSW; n++) begin
            if (o_Repeat[n] === 1'b1) obsRepeat[n]++;
            if (o_Long[n] === 1'b1) obsLong[n]++;
            if (o_Press[n] === 1'b1) obsPressCount[n]++;
        end
    endtask

    task automatic clearObserved();
        for (int n = 0; n < NSW; n++) begin
            obsRepeat[n] = 0;
            obsLong[n] = 0;
            obsPressCount[n] = 0;
        end
    endtask

    initial begin
        logic [NSW-1:0] sw;
        logic en;
        logic rstL;
        for (int n = 0; n < NSW; n++) begin
            mActive[n] = 1'b0;
            mLong[n] = 1'b0;
            mPrev[n] = 1'b0;
            mRise[n] = 0;
            mRef[n] = 0;
        end
        clearObserved();

        // Reset held low, then released with no switch activity.
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (2) applyStimulus(4'b0000, 1'b0, 1'b1);

        // Short press on channel 0.
        clearObserved();
        repeat (5) applyStimulus(4'b0001, 1'b0, 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("ch0_presses", 32'(obsPressCount[0]), 32'd1);
        checkOutput("ch0_longs", 32'(obsLong[0]), 32'd0);

        // Long hold with repeats on channel 1; the release lands on a repeat threshold.
        clearObserved();
        repeat (20) applyStimulus(4'b0010, 1'b1, 1'b1);
        repeat (4) applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("ch1_longs", 32'(obsLong[1]), 32'd1);
        checkOutput("ch1_repeats", 32'(obsRepeat[1]), 32'd3);

        // Release exactly on the long-press threshold edge for channel 2.
        clearObserved();
        repeat (8) applyStimulus(4'b0100, 1'b1, 1'b1);
        repeat (3) applyStimulus(4'b0000, 1'b1, 1'b1);
        checkOutput("ch2_longs", 32'(obsLong[2]), 32'd0);

        // Repeat enable toggled off and back on during a long hold on channel 3.
        clearObserved();
        repeat (12) applyStimulus(4'b1000, 1'b1, 1'b1);
        repeat (6) applyStimulus(4'b1000, 1'b0, 1'b1);
        repeat (7) applyStimulus(4'b1000, 1'b1, 1'b1);
        repeat (2) applyStimulus(4'b0000, 1'b1, 1'b1);

        // Release then press with a one-cycle gap.
        repeat (3) applyStimulus(4'b0001, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        repeat (3) applyStimulus(4'b0001, 1'b0, 1'b1);
        repeat (2) applyStimulus(4'b0000, 1'b0, 1'b1);

        // Simultaneous presses, reset mid-hold, switches still high afterwards.
        clearObserved();
        repeat (4) applyStimulus(4'b0101, 1'b1, 1'b1);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        repeat (3) applyStimulus(4'b0101, 1'b1, 1'b1);
        checkOutput("ch0_repress", 32'(obsPressCount[0]), 32'd2);
        checkOutput("ch2_repress", 32'(obsPressCount[2]), 32'd2);
        repeat (2) applyStimulus(4'b0000, 1'b1, 1'b1);

        // Random traffic: slow switch toggling, occasional enable flips and rare resets.
        sw = '0;
        en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < NSW; n++)
                if ($urandom_range(0, 9) == 0) sw[n] = ~sw[n];
            if ($urandom_range(0, 24) == 0) en = ~en;
            rstL = ($urandom_range(0, 299) != 0);
            applyStimulus(sw, en, rstL);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
